// File: rtl/cpu_mem_responder_if.sv
// Core/host side bundle for cpu_mem_responder: instruction port, data port,
// host preload port and the core hold line.
interface cpu_mem_responder_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] im_addr;
   logic [DATA_W-1:0] im_instr;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_data_in;
   logic              dm_web;
   logic [DATA_W-1:0] dm_bweb;
   logic [DATA_W-1:0] dm_data_out;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              cpu_hold;

   modport master (
      output im_addr, dm_addr, dm_data_in, dm_web, dm_bweb,
             ld_valid, ld_addr, ld_data, ld_last,
      input  im_instr, dm_data_out, ld_ready, cpu_hold
   );

   modport slave (
      input  im_addr, dm_addr, dm_data_in, dm_web, dm_bweb,
             ld_valid, ld_addr, ld_data, ld_last,
      output im_instr, dm_data_out, ld_ready, cpu_hold
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Shared instruction/data word memory for the core, with a power-up clear
// sweep and host preload phase that hold the core until the last preload word.
//
// state | meaning
// CLEAR | zeroing one word per cycle, core held
// LOAD  | accepting host preload words, core held
// RUN   | serving core ports, terminal until reset
module cpu_mem_responder #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 2**ADDR_W,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic               clk,
   input logic               rst,
   cpu_mem_responder_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

   state_t            state;
   logic [CNT_W-1:0]  clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0] im_idx, dm_idx, ld_idx, clr_idx;
   logic             ld_fire;
   logic             dm_we;

   assign im_idx  = bus.im_addr[IDX_W-1:0];
   assign dm_idx  = bus.dm_addr[IDX_W-1:0];
   assign ld_idx  = bus.ld_addr[IDX_W-1:0];
   assign clr_idx = clr_cnt[IDX_W-1:0];

   assign bus.ld_ready = (state == LOAD);
   assign ld_fire      = bus.ld_valid && (state == LOAD);
   assign dm_we        = (state == RUN) && !bus.dm_web;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;
         clr_cnt         <= '0;
         bus.im_instr    <= '0;
         bus.dm_data_out <= '0;
         bus.cpu_hold    <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == CNT_W'(DEPTH - 1)) state <= LOAD;
            end
            LOAD: begin
               if (ld_fire && bus.ld_last) begin
                  state        <= RUN;
                  bus.cpu_hold <= 1'b0;
               end
            end
            RUN: begin
               // Read-first: nonblocking reads see the pre-write word on collisions.
               bus.im_instr    <= mem[im_idx];
               bus.dm_data_out <= mem[dm_idx];
            end
            default: state <= (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;
         endcase
      end
   end

   // Reset gates every write so a handshake in flight during reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == CLEAR) begin
            mem[clr_idx] <= '0;
         end else if (ld_fire) begin
            mem[ld_idx] <= bus.ld_data;
         end else if (dm_we) begin
            mem[dm_idx] <= (mem[dm_idx] & bus.dm_bweb) | (bus.dm_data_in & ~bus.dm_bweb);
         end
      end
   end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: one instance with the clear sweep,
// one without, both with a 16-word array.
module tb_cpu_mem_responder;
   localparam int AW = 14;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cpu_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   cpu_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .CLEAR_ON_RESET(1)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(16), .CLEAR_ON_RESET(0)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      bus_a.im_addr = '0; bus_a.dm_addr = '0; bus_a.dm_data_in = '0;
      bus_a.dm_web = 1'b1; bus_a.dm_bweb = '1;
      bus_a.ld_valid = 1'b0; bus_a.ld_addr = '0; bus_a.ld_data = '0; bus_a.ld_last = 1'b0;
      bus_b.im_addr = '0; bus_b.dm_addr = '0; bus_b.dm_data_in = '0;
      bus_b.dm_web = 1'b1; bus_b.dm_bweb = '1;
      bus_b.ld_valid = 1'b0; bus_b.ld_addr = '0; bus_b.ld_data = '0; bus_b.ld_last = 1'b0;

      // Reset state of the clearing instance
      tick(); tick();
      chk("rst_hold", bus_a.cpu_hold, 1);
      chk("rst_ready", bus_a.ld_ready, 0);
      chk("rst_im", bus_a.im_instr, 0);
      chk("rst_dm", bus_a.dm_data_out, 0);

      // Sweep of 16 words: ready rises on the 16th edge after release
      rst_a = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         chk("sweep_ready", bus_a.ld_ready, (n == 16) ? 1 : 0);
         chk("sweep_hold", bus_a.cpu_hold, 1);
         chk("sweep_im", bus_a.im_instr, 0);
      end

      // Preload with a gap; a CPU write during LOAD must be ignored
      bus_a.dm_web = 1'b0; bus_a.dm_addr = 3; bus_a.dm_data_in = 32'hFFFF_FFFF; bus_a.dm_bweb = '0;
      bus_a.ld_valid = 1'b1; bus_a.ld_addr = 0; bus_a.ld_data = 32'h0000_0013; bus_a.ld_last = 1'b0;
      tick();
      chk("load_hold0", bus_a.cpu_hold, 1);
      chk("load_im0", bus_a.im_instr, 0);
      bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b1;
      tick();
      chk("last_no_valid_hold", bus_a.cpu_hold, 1);
      chk("last_no_valid_ready", bus_a.ld_ready, 1);
      bus_a.ld_valid = 1'b1; bus_a.ld_addr = 5; bus_a.ld_data = 32'hDEAD_BEEF; bus_a.ld_last = 1'b1;
      tick();
      chk("run_hold", bus_a.cpu_hold, 0);
      chk("run_ready", bus_a.ld_ready, 0);
      chk("run_dm_idle", bus_a.dm_data_out, 0);

      // In RUN a stray preload beat must not touch the array
      bus_a.dm_web = 1'b1; bus_a.dm_bweb = '1; bus_a.dm_data_in = '0;
      bus_a.ld_valid = 1'b1; bus_a.ld_addr = 5; bus_a.ld_data = 32'h0; bus_a.ld_last = 1'b1;
      bus_a.im_addr = 5;
      tick();
      chk("im_5", bus_a.im_instr, 32'hDEAD_BEEF);
      bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
      bus_a.im_addr = 0;
      tick();
      chk("im_0", bus_a.im_instr, 32'h0000_0013);
      bus_a.im_addr = 3;
      tick();
      chk("im_3_cleared", bus_a.im_instr, 0);
      bus_a.im_addr = 5;
      tick();
      chk("im_5_after_stray", bus_a.im_instr, 32'hDEAD_BEEF);

      // Byte store into bits 15:8, read-first then updated word
      bus_a.dm_addr = 5; bus_a.dm_web = 1'b0; bus_a.dm_bweb = 32'hFFFF_00FF; bus_a.dm_data_in = 32'h0000_1200;
      tick();
      chk("byte_read_first", bus_a.dm_data_out, 32'hDEAD_BEEF);
      bus_a.dm_web = 1'b1;
      tick();
      chk("byte_after", bus_a.dm_data_out, 32'hDEAD_12EF);

      // Collision between instruction read and data write at address 7
      bus_a.dm_addr = 7; bus_a.dm_web = 1'b0; bus_a.dm_bweb = '0; bus_a.dm_data_in = 32'h1111_1111;
      tick();
      bus_a.im_addr = 7; bus_a.dm_data_in = 32'h2222_2222;
      tick();
      chk("coll_im_old", bus_a.im_instr, 32'h1111_1111);
      chk("coll_dm_old", bus_a.dm_data_out, 32'h1111_1111);
      bus_a.dm_web = 1'b1;
      tick();
      chk("coll_im_new", bus_a.im_instr, 32'h2222_2222);

      // dm_web high blocks a write even with an all-enable mask
      bus_a.dm_addr = 5; bus_a.dm_web = 1'b1; bus_a.dm_bweb = '0; bus_a.dm_data_in = 32'hFFFF_FFFF;
      tick(); tick();
      chk("web_high_nowrite", bus_a.dm_data_out, 32'hDEAD_12EF);

      // All-ones bit mask with dm_web low is a no-op
      bus_a.dm_web = 1'b0; bus_a.dm_bweb = '1; bus_a.dm_data_in = 32'h0;
      tick();
      bus_a.dm_web = 1'b1;
      tick();
      chk("bweb_ones_nop", bus_a.dm_data_out, 32'hDEAD_12EF);

      // Reset in RUN, then reset mid-sweep; the sweep restarts from word 0
      rst_a = 1'b0;
      tick();
      chk("rerst_hold", bus_a.cpu_hold, 1);
      chk("rerst_ready", bus_a.ld_ready, 0);
      chk("rerst_im", bus_a.im_instr, 0);
      chk("rerst_dm", bus_a.dm_data_out, 0);
      rst_a = 1'b1;
      repeat (5) tick();
      rst_a = 1'b0;
      tick();
      rst_a = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         chk("resweep_ready", bus_a.ld_ready, (n == 16) ? 1 : 0);
      end
      bus_a.ld_valid = 1'b1; bus_a.ld_addr = 0; bus_a.ld_data = 32'h0000_0013; bus_a.ld_last = 1'b1;
      tick();
      chk("reload_hold", bus_a.cpu_hold, 0);
      bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
      bus_a.im_addr = 5; bus_a.dm_addr = 7;
      tick();
      chk("cleared_5", bus_a.im_instr, 0);
      chk("cleared_7", bus_a.dm_data_out, 0);

      // Instance without a clear sweep: LOAD straight out of reset
      tick();
      chk("b_rst_ready", bus_b.ld_ready, 1);
      chk("b_rst_hold", bus_b.cpu_hold, 1);
      rst_b = 1'b1;
      bus_b.ld_valid = 1'b1; bus_b.ld_addr = 5; bus_b.ld_data = 32'hDEAD_12EF; bus_b.ld_last = 1'b1;
      tick();
      chk("b_run_hold", bus_b.cpu_hold, 0);
      bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0; bus_b.dm_addr = 5;
      tick();
      chk("b_dm_5", bus_b.dm_data_out, 32'hDEAD_12EF);

      // Reset in RUN with a preload beat presented during reset: dropped
      rst_b = 1'b0;
      bus_b.ld_valid = 1'b1; bus_b.ld_addr = 5; bus_b.ld_data = 32'h0; bus_b.ld_last = 1'b1;
      tick();
      chk("b_rerst_hold", bus_b.cpu_hold, 1);
      chk("b_rerst_ready", bus_b.ld_ready, 1);
      chk("b_rerst_dm", bus_b.dm_data_out, 0);
      rst_b = 1'b1;
      bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
      tick();
      chk("b_nosweep_ready", bus_b.ld_ready, 1);
      chk("b_nosweep_hold", bus_b.cpu_hold, 1);
      bus_b.ld_valid = 1'b1; bus_b.ld_addr = 1; bus_b.ld_data = 32'h0000_CAFE; bus_b.ld_last = 1'b1;
      tick();
      chk("b_rerun_hold", bus_b.cpu_hold, 0);
      bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
      bus_b.dm_addr = 5; bus_b.im_addr = 1;
      tick();
      chk("b_kept_5", bus_b.dm_data_out, 32'hDEAD_12EF);
      chk("b_im_1", bus_b.im_instr, 32'h0000_CAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU core's instruction and data memory ports.
- Serves the read-only instruction port and the read/write data port from one shared word array. Both are synchronous reads with 1-cycle latency, which matches the core's M-stage address / WB-stage load-data timing.
- Contains a power-up sequencer: an optional clear sweep, then a host preload phase over a valid/ready port. During both, the core is held through cpu_hold.
- Release to RUN happens only after the host marks the last preload word.

Parameters:
ADDR_W, 14, word-address width of both CPU ports and the load port
DATA_W, 32, word width
DEPTH, 2**ADDR_W, number of words in the array
CLEAR_ON_RESET, 1, 1 = zero every word after reset before LOAD; 0 = skip straight to LOAD and keep contents

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
im_addr  in  ADDR_W  instruction word address from core
im_instr  out  DATA_W  instruction read data, registered
dm_addr  in  ADDR_W  data word address from core
dm_data_in  in  DATA_W  store data, pre-aligned by core
dm_web  in  1  active-low write enable
dm_bweb  in  DATA_W  active-low per-bit write mask
dm_data_out  out  DATA_W  load read data, registered
ld_valid  in  1  host preload word valid
ld_ready  out  1  responder accepts preload word
ld_addr  in  ADDR_W  preload word address
ld_data  in  DATA_W  preload word
ld_last  in  1  qualifies the final preload word
cpu_hold  out  1  1 = core must be held in reset

Behaviour:
- Reset (rst==0 at a rising edge):
  - state <= CLEAR if CLEAR_ON_RESET, else LOAD; clr_cnt <= 0.
  - im_instr <= 0, dm_data_out <= 0, cpu_hold <= 1.
  - Array contents are not touched by reset itself.
- ld_ready is combinational: (state==LOAD).
- CLEAR state:
  - Each cycle writes mem[clr_cnt] <= 0, then clr_cnt++.
  - After writing word DEPTH-1, go to LOAD next cycle. The sweep takes exactly DEPTH cycles.
  - clr_cnt is ADDR_W+1 bits wide and must not wrap before the terminal compare.
- LOAD state:
  - On ld_valid&&ld_ready, mem[ld_addr] <= ld_data (full word).
  - If ld_last is also set, state <= RUN next cycle.
  - ld_last without ld_valid is ignored.
  - A repeated address takes the last write.
- CLEAR and LOAD, CPU side:
  - dm_web and dm_bweb are ignored; no CPU write reaches the array.
  - im_instr and dm_data_out are driven 0.
  - cpu_hold stays 1.
- RUN state:
  - cpu_hold <= 0 on the edge that enters RUN; it stays 0 until the next reset.
  - ld_ready = 0; ld_* inputs are ignored.
  - RUN is terminal; only rst leaves it.
- Instruction port (RUN): im_instr(t+1) = mem[im_addr(t)].
- Data port read (RUN): dm_data_out(t+1) = mem[dm_addr(t)].
  - This is read-first: on a write cycle it returns the pre-write word.
- Data port write (RUN, dm_web==0): for each bit i with dm_bweb[i]==0, mem[dm_addr][i] <= dm_data_in[i]. Bits with dm_bweb[i]==1 keep their value.
  - dm_web==1 means no write, regardless of dm_bweb.
  - dm_bweb all-ones with dm_web==0 is a legal no-op.
- Same-cycle collision: im_addr==dm_addr with a write → im_instr returns the old word; the new word is visible from the next cycle's read.
- Reset asserted mid-CLEAR, mid-LOAD or in RUN:
  - Sweep restarts from word 0; any in-flight preload handshake is dropped.
  - cpu_hold returns to 1 on that edge.
- No X propagation: unwritten words read 0 when CLEAR_ON_RESET=1.

Test Plan:
- Reset, CLEAR_ON_RESET=1, DEPTH=16 override → ld_ready rises exactly 16 cycles after rst deasserts; cpu_hold=1 throughout; im_instr=0.
- LOAD: words 0x00000013@0, 0xDEADBEEF@5, ld_last on the second; ld_valid gapped for one cycle between them → cpu_hold falls the edge after the last beat. im_addr=5 gives im_instr=0xDEADBEEF one cycle later.
- Byte store: mem[5]=0xDEADBEEF, dm_web=0, dm_bweb=0xFFFF00FF, dm_data_in=0x00001200 → same-cycle read gives dm_data_out=0xDEADBEEF; next read gives 0xDEAD12EF.
- Collision: im_addr=dm_addr=7, mem[7]=0x11111111, full-word write 0x22222222 → im_instr=0x11111111; the following cycle im_instr=0x22222222.
- dm_web=1 with dm_bweb=0 and dm_data_in=0xFFFFFFFF at addr 5 → no change; a read still returns 0xDEAD12EF.
- Reset in RUN with CLEAR_ON_RESET=0 → no sweep, ld_ready=1 next cycle, cpu_hold=1; mem[5] still reads 0xDEAD12EF after re-entering RUN via a single ld_last beat.
